iter_divider: RTL and testbench

//  Parametrised multi-cycle integer divider for the RV32M DIV/DIVU/REM/REMU instructions.
//  It is the sequential successor to the single-cycle 32-bit adder.

---
 rtl/mdu_pkg.sv | 23 ++
 rtl/div_step.sv | 31 +++
 rtl/iter_divider.sv | 186 ++++++++++++++++++
 tb/tb_iter_divider.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared types and defaults for the multiply/divide unit.
//   div_op_e    : operation encoding, matches funct3[1:0] of DIV/DIVU/REM/REMU
//   div_state_e : iterative divider control states
package mdu_pkg;

    localparam int unsigned XLEN_DEFAULT  = 32;
    localparam int unsigned STEPS_DEFAULT = 1;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step.
// Ports:
//   rem_i     : partial remainder (always < divisor_i)
//   quo_i     : dividend bits still to shift in, quotient bits shifted in at the bottom
//   divisor_i : divisor magnitude
//   rem_o     : updated partial remainder
//   quo_o     : quo_i shifted left with the new quotient bit in bit 0
module div_step
    import mdu_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quo_o
);

    // The shifted remainder needs XLEN+1 bits: it can reach 2*divisor-1.
    logic [XLEN:0] rem_sh;
    logic [XLEN:0] diff;

    assign rem_sh = {rem_i, quo_i[XLEN-1]};
    assign diff   = rem_sh - {1'b0, divisor_i};

    // A borrow (diff MSB set) means rem_sh < divisor: keep rem_sh, quotient bit 0.
    assign rem_o = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
    assign quo_o = {quo_i[XLEN-2:0], ~diff[XLEN]};

endmodule

// File: rtl/iter_divider.sv
// Multi-cycle RV32M divider (DIV/DIVU/REM/REMU), restoring algorithm,
// STEPS_PER_CYCLE quotient bits per cycle, valid/ready on both sides.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   flush               : kill any in-flight or completed operation
//   in_valid/in_ready   : operand handshake (op, a, b)
//   out_valid/out_ready : result handshake (result)
module iter_divider
    import mdu_pkg::*;
#(
    parameter int unsigned XLEN            = XLEN_DEFAULT,
    parameter int unsigned STEPS_PER_CYCLE = STEPS_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    localparam int unsigned N     = XLEN / STEPS_PER_CYCLE;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  rem_q, rem_d;
    logic [XLEN-1:0]  quo_q, quo_d;
    logic [XLEN-1:0]  div_q, div_d;
    logic             quo_neg_q, quo_neg_d;
    logic             rem_neg_q, rem_neg_d;
    logic             op_rem_q, op_rem_d;
    logic [XLEN-1:0]  result_q, result_d;
    logic             out_valid_q, out_valid_d;

    // Operand decode for the IDLE accept path.
    div_op_e         op_e;
    logic            is_signed;
    logic            is_rem;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_abs;
    logic [XLEN-1:0] b_abs;
    logic            accept;

    assign op_e      = div_op_e'(op);
    assign is_signed = (op_e == OP_DIV) || (op_e == OP_REM);
    assign is_rem    = (op_e == OP_REM) || (op_e == OP_REMU);
    assign a_neg     = is_signed & a[XLEN-1];
    assign b_neg     = is_signed & b[XLEN-1];
    assign a_abs     = a_neg ? (XLEN'(0) - a) : a;
    assign b_abs     = b_neg ? (XLEN'(0) - b) : b;

    assign in_ready  = rst_n && (state_q == IDLE);
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign result    = result_q;

    // Restoring step chain: STEPS_PER_CYCLE steps per clock.
    logic [XLEN-1:0] rem_chain [STEPS_PER_CYCLE+1];
    logic [XLEN-1:0] quo_chain [STEPS_PER_CYCLE+1];

    assign rem_chain[0] = rem_q;
    assign quo_chain[0] = quo_q;

    for (genvar g = 0; g < STEPS_PER_CYCLE; g++) begin : g_step
        div_step #(
            .XLEN(XLEN)
        ) u_step (
            .rem_i    (rem_chain[g]),
            .quo_i    (quo_chain[g]),
            .divisor_i(div_q),
            .rem_o    (rem_chain[g+1]),
            .quo_o    (quo_chain[g+1])
        );
    end

    // Sign fixup applied in FIX.
    logic [XLEN-1:0] quo_fix;
    logic [XLEN-1:0] rem_fix;

    assign quo_fix = quo_neg_q ? (XLEN'(0) - quo_q) : quo_q;
    assign rem_fix = rem_neg_q ? (XLEN'(0) - rem_q) : rem_q;

    // Next-state and datapath update.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        div_d       = div_q;
        quo_neg_d   = quo_neg_q;
        rem_neg_d   = rem_neg_q;
        op_rem_d    = op_rem_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;

        if (flush) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (b == '0) begin
                            result_d    = is_rem ? a : '1;
                            out_valid_d = 1'b1;
                            state_d     = DONE;
                        end else if (is_signed && (a == MIN_VAL) && (b == '1)) begin
                            result_d    = is_rem ? '0 : MIN_VAL;
                            out_valid_d = 1'b1;
                            state_d     = DONE;
                        end else begin
                            rem_d     = '0;
                            quo_d     = a_abs;
                            div_d     = b_abs;
                            quo_neg_d = a_neg ^ b_neg;
                            rem_neg_d = a_neg;
                            op_rem_d  = is_rem;
                            cnt_d     = CNT_W'(N - 1);
                            state_d   = CALC;
                        end
                    end
                end
                CALC: begin
                    rem_d = rem_chain[STEPS_PER_CYCLE];
                    quo_d = quo_chain[STEPS_PER_CYCLE];
                    if (cnt_q == '0) begin
                        state_d = FIX;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                FIX: begin
                    result_d    = op_rem_q ? rem_fix : quo_fix;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = IDLE;
                    end
                end
                default: begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            div_q       <= '0;
            quo_neg_q   <= 1'b0;
            rem_neg_q   <= 1'b0;
            op_rem_q    <= 1'b0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            div_q       <= div_d;
            quo_neg_q   <= quo_neg_d;
            rem_neg_q   <= rem_neg_d;
            op_rem_q    <= op_rem_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_iter_divider.sv
// Directed and randomized checks of iter_divider against an arithmetic reference.
module tb_iter_divider;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;

    logic        flush2;
    logic        in_valid2;
    logic        in_ready2;
    logic [1:0]  op2;
    logic [31:0] a2;
    logic [31:0] b2;
    logic        out_valid2;
    logic        out_ready2;
    logic [31:0] result2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    iter_divider #(.XLEN(32), .STEPS_PER_CYCLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result)
    );

    iter_divider #(.XLEN(32), .STEPS_PER_CYCLE(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .flush(flush2),
        .in_valid(in_valid2), .in_ready(in_ready2), .op(op2), .a(a2), .b(b2),
        .out_valid(out_valid2), .out_ready(out_ready2), .result(result2)
    );

    // Reference: RISC-V division semantics from plain signed/unsigned arithmetic.
    function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic signed [31:0] sx;
        logic signed [31:0] sy;
        sx = x;
        sy = y;
        if (y == 32'd0) return o[1] ? x : 32'hFFFF_FFFF;
        if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
            return o[1] ? 32'd0 : 32'h8000_0000;
        case (o)
            2'b00:   return sx / sy;
            2'b01:   return x / y;
            2'b10:   return sx % sy;
            default: return x % y;
        endcase
    endfunction

    function automatic int ref_lat(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input int n);
        if (y == 32'd0) return 1;
        if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
        return n + 2;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 255));
            default: return 32'($urandom);
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one op on dut, wait for out_valid, optionally stall, then hand off.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input int hold, output logic [31:0] res, output int lat);
        @(negedge clk);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1; op = o; a = x; b = y; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        check("in_ready_busy", 32'(in_ready), 32'd0);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        res = result;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_result", result, res);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic run_op2(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                           output logic [31:0] res, output int lat);
        @(negedge clk);
        check("in_ready2_idle", 32'(in_ready2), 32'd1);
        in_valid2 = 1'b1; op2 = o; a2 = x; b2 = y; out_ready2 = 1'b0;
        @(negedge clk);
        in_valid2 = 1'b0;
        lat = 1;
        while (out_valid2 !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        res = result2;
        out_ready2 = 1'b1;
        @(negedge clk);
        out_ready2 = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  o;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] r;
        int          l;
    } dir_t;

    initial begin
        dir_t        dirs [8];
        logic [31:0] res;
        logic [31:0] last_res;
        int          lat;
        int          bad;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; op = 2'b00; a = '0; b = '0; out_ready = 1'b0;
        flush2 = 1'b0; in_valid2 = 1'b0; op2 = 2'b00; a2 = '0; b2 = '0; out_ready2 = 1'b0;

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Directed cases with hand-derived results.
        dirs[0] = '{2'b01, 32'd100,        32'd7,          32'd14,         34};
        dirs[1] = '{2'b11, 32'd100,        32'd7,          32'd2,          34};
        dirs[2] = '{2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  34};
        dirs[3] = '{2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  34};
        dirs[4] = '{2'b00, 32'd5,          32'd0,          32'hFFFF_FFFF,  1};
        dirs[5] = '{2'b10, 32'd5,          32'd0,          32'd5,          1};
        dirs[6] = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
        dirs[7] = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1};
        foreach (dirs[i]) begin
            run_op(dirs[i].o, dirs[i].x, dirs[i].y, 0, res, lat);
            check($sformatf("dir%0d_result", i), res, dirs[i].r);
            check($sformatf("dir%0d_latency", i), 32'(lat), 32'(dirs[i].l));
        end

        // Back-pressure: result held for 10 stalled cycles, in_ready returns after handshake.
        run_op(2'b01, 32'd1000, 32'd10, 10, res, lat);
        check("stall_result", res, 32'd100);
        check("stall_latency", 32'(lat), 32'd34);
        check("stall_in_ready_after", 32'(in_ready), 32'd1);
        check("stall_out_valid_after", 32'(out_valid), 32'd0);
        last_res = 32'd100;

        // Flush in cycle 10 of a DIV.
        @(negedge clk);
        in_valid = 1'b1; op = 2'b00; a = 32'd12345; b = 32'd7;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_in_ready", 32'(in_ready), 32'd1);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_result_kept", result, last_res);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) bad++;
        end
        check("flush_no_result", 32'(bad), 32'd0);

        // Synchronous reset in the middle of CALC.
        @(negedge clk);
        in_valid = 1'b1; op = 2'b01; a = 32'd999; b = 32'd4;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_result", result, 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_in_ready_after", 32'(in_ready), 32'd1);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) bad++;
        end
        check("midrst_no_result", 32'(bad), 32'd0);

        // Randomized ops against the reference.
        for (int i = 0; i < 40; i++) begin
            logic [1:0]  ro;
            logic [31:0] rx;
            logic [31:0] ry;
            ro = 2'($urandom_range(0, 3));
            rx = pick_operand();
            ry = pick_operand();
            run_op(ro, rx, ry, int'($urandom_range(0, 2)), res, lat);
            check($sformatf("rnd%0d_op%0d_%0h_%0h", i, ro, rx, ry), res, ref_div(ro, rx, ry));
            check($sformatf("rnd%0d_latency", i), 32'(lat), 32'(ref_lat(ro, rx, ry, 32)));
        end

        // Two steps per cycle.
        run_op2(2'b01, 32'hFFFF_FFFF, 32'd3, res, lat);
        check("s2_result", res, 32'h5555_5555);
        check("s2_latency", 32'(lat), 32'd18);
        for (int i = 0; i < 12; i++) begin
            logic [1:0]  ro;
            logic [31:0] rx;
            logic [31:0] ry;
            ro = 2'($urandom_range(0, 3));
            rx = pick_operand();
            ry = pick_operand();
            run_op2(ro, rx, ry, res, lat);
            check($sformatf("s2rnd%0d_op%0d_%0h_%0h", i, ro, rx, ry), res, ref_div(ro, rx, ry));
            check($sformatf("s2rnd%0d_latency", i), 32'(lat), 32'(ref_lat(ro, rx, ry, 16)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
